ram_dp_clr: RTL
===============

# ram_dp_clr

Parametrised simple dual-port RAM (one write port, one read port) with a built-in clear engine, selectable read-during-write behaviour and an optional output pipeline register. It holds the A/B operand and C result matrices for the matrix-multiply datapath. It replaces the fixed 64x8 single-port file-initialised RAM: contents are now initialised by hardware (reset or `clr`) rather than by a simulation file, and read and write addresses are independent.

## Interface
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 6: address width; depth `DEPTH = 2**ADDR_W` (derived, not overridable).
- `RDW_MODE`, 0: same-address read-during-write result; 0 = old data, 1 = new data (write-through bypass).
- `CLR_VAL`, 0: `DATA_W`-bit value written to every location by the clear engine.
- `OUT_REG`, 0: 0 = read latency 1; 1 = extra output register, read latency 2.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  single-cycle request to re-clear the whole array.
- `busy`  out  1  high while the clear engine owns the array.
- `we`  in  1  write enable.
- `waddr`  in  `ADDR_W`  write address.
- `wdata`  in  `DATA_W`  write data.
- `re`  in  1  read enable.
- `raddr`  in  `ADDR_W`  read address.
- `rdata`  out  `DATA_W`  registered read data.
- `rvalid`  out  1  one-cycle strobe; `rdata` is valid for the read that produced it.

## Operation
- FSM states: `CLEAR` and `READY`. A counter `clr_cnt` (`ADDR_W` bits) addresses the array during `CLEAR`.
- Reset (`rst_n`=0, asynchronous):
  - state=`CLEAR`, `clr_cnt`=0, `busy`=1.
  - `rdata`=0, `rvalid`=0, `OUT_REG` stage cleared.
  - Array contents are not reset directly.
- `CLEAR`:
  - Each edge writes `CLR_VAL` to `mem[clr_cnt]`, then increments `clr_cnt`.
  - The edge that writes `DEPTH-1` moves the FSM to `READY`, `clr_cnt` wraps to 0, and `busy` drops.
  - `we`, `re` and `clr` are ignored while `busy`=1. No writes from the write port; `rvalid` stays 0 for new requests.
- `READY`:
  - `busy`=0.
  - `we`=1: `mem[waddr] <= wdata`.
  - `re`=1: read `mem[raddr]`.
  - `clr`=1: the FSM enters `CLEAR` at that edge and `busy`=1 next cycle. A write or read presented on that same edge is still performed. The write is later overwritten by the clear.
- Read-during-write (`we`=`re`=1, `raddr`=`waddr`, `READY`):
  - `RDW_MODE`=0 returns the pre-write contents.
  - `RDW_MODE`=1 returns `wdata`.
  - Different addresses never interact.
- `rdata` holds its last value when no read completes; it is not zeroed.
- With `OUT_REG`=1, a read accepted before `clr` still completes and asserts `rvalid` during `CLEAR`.

## Timing
- Clear duration: `busy`=1 from reset assertion through exactly `DEPTH` rising edges after `rst_n` release. The first `READY` edge is the `DEPTH+1`-th edge. A `clr`-initiated clear keeps `busy`=1 for `DEPTH` cycles.
- Read latency:
  - `OUT_REG`=0: `re` sampled at edge N gives `rdata`/`rvalid` valid after edge N.
  - `OUT_REG`=1: valid after edge N+1.
- Back-to-back reads every cycle are supported at full throughput, one `rvalid` per accepted `re`.
- Write latency: data is visible to a read issued on the edge after the write (old data on the same edge when `RDW_MODE`=0).
- Reset mid-clear or mid-read: all pipeline state is dropped, `rvalid`=0 immediately, and the clear restarts from address 0.

## Test plan
- Reset release, `DATA_W`=8, `ADDR_W`=6, `CLR_VAL`=8'hA5:
  - `busy`=1 for exactly 64 edges, then 0.
  - Reading addresses 0..63 returns 8'hA5 with `rvalid` one cycle after each `re`.
- Write 8'h3C to 17, then read 17 on the next cycle -> `rdata`=8'h3C, `rvalid`=1 for one cycle. With `OUT_REG`=1, same values one cycle later.
- Same-cycle `we`=`re`=1 at addr 5, mem[5]=8'h11, `wdata`=8'h22:
  - `RDW_MODE`=0 -> `rdata`=8'h11.
  - `RDW_MODE`=1 -> `rdata`=8'h22.
  - A following read of 5 returns 8'h22.
- Fill RAM with address values, pulse `clr`:
  - `busy` rises next cycle for 64 cycles.
  - `we`/`re` during `busy` produce no `rvalid` and no writes.
  - Afterwards every word = `CLR_VAL`.
- Assert `rst_n`=0 asynchronously at clear count 30 with a read in flight (`OUT_REG`=1):
  - `rvalid` and `rdata` go to 0 immediately.
  - After release, `busy` lasts a full 64 cycles.
- Random interleaved reads and writes with distinct addresses against a reference model for 10k cycles -> zero mismatches, `rvalid` count equals accepted `re` count.

Source files
------------

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with a hardware clear engine, selectable read-during-write
// behaviour and an optional second output register stage.
`timescale 1ns/1ps

module ram_dp_clr #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0,
    parameter int                OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                rd_go;
    logic                rd_bypass;
    logic [DATA_W-1:0]   rd_data_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   s1_data_q;
    logic                s1_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADR) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // While clearing, the engine owns the write port and all requests are dropped.
    always_comb begin
        busy      = (state_q == CLEAR);
        rd_go     = 1'b0;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLR_VAL;
        if (state_q == READY) begin
            rd_go     = re;
            mem_we    = we;
            mem_waddr = waddr;
            mem_wdata = wdata;
        end
    end

    // NOTE: the array has no reset; its contents are initialised by the clear engine instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_bypass = (RDW_MODE != 0) && we && (waddr == raddr);
    assign rd_data_d = rd_bypass ? wdata : mem_q[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_go;
            if (rd_go) begin
                s1_data_q <= rd_data_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data_q;
            logic              s2_valid_q;

            // The second stage keeps draining during a clear so in-flight reads complete.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rdata  = s2_data_q;
            assign rvalid = s2_valid_q;
        end else begin : g_no_out_reg
            assign rdata  = s1_data_q;
            assign rvalid = s1_valid_q;
        end
    endgenerate

endmodule
